// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS writeback path.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  // Architectural zero register; never written.
  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4
  } load_type_e;

endpackage

// File: rtl/load_align.sv
// Load data extractor: picks the addressed byte/halfword from a big-endian
// memory word and sign- or zero-extends it. Purely combinational.
module load_align
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        load_type_i,
  input  logic [1:0]        byte_off_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] aligned_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    sel_byte = rdata_i[31:24];
    unique case (byte_off_i)
      2'd0: sel_byte = rdata_i[31:24];
      2'd1: sel_byte = rdata_i[23:16];
      2'd2: sel_byte = rdata_i[15:8];
      2'd3: sel_byte = rdata_i[7:0];
      default: sel_byte = rdata_i[31:24];
    endcase
    // byte_off_i[0] is irrelevant for halfwords; misalignment traps upstream.
    sel_half = byte_off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  // Extension by load type; LW and unknown encodings pass the raw word.
  always_comb begin
    aligned_o = rdata_i;
    case (load_type_i)
      LB:      aligned_o = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      LBU:     aligned_o = {{(DATA_W-8){1'b0}}, sel_byte};
      LH:      aligned_o = {{(DATA_W-16){sel_half[15]}}, sel_half};
      LHU:     aligned_o = {{(DATA_W-16){1'b0}}, sel_half};
      default: aligned_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates in-order MEM results against a one-entry
// mult/div holding buffer and drives the registered register-file write port.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_byte_off,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_dest,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic [ADDR_W-1:0] address_write,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  output logic              hold_pending,
  output logic [ADDR_W-1:0] hold_dest,
  output logic              stall_req
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0]   CntMax = CntW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] Zero   = ADDR_W'(REG_ZERO);

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_dest_q, hold_dest_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;

  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_wr;
  logic              md_xfer;

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .load_type_i (mem_load_type),
    .byte_off_i  (mem_byte_off),
    .rdata_i     (mem_rdata),
    .aligned_o   (load_word)
  );

  assign pipe_data = mem_is_load ? load_word : mem_result;
  assign pipe_wr   = mem_valid && (mem_dest != Zero);
  assign md_ready  = !hold_valid_q;
  // md_ready depends only on current occupancy, so accept never overlaps a drain.
  assign md_xfer   = md_valid && md_ready;

  // Write-port arbitration, hold-buffer update and starvation counter.
  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    hold_valid_d = hold_valid_q;
    hold_dest_d  = hold_dest_q;
    hold_data_d  = hold_data_q;
    wait_cnt_d   = '0;

    if (pipe_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = mem_dest;
      wr_data_d = pipe_data;
      // Held result is older; a younger write to the same register supersedes it.
      if (hold_valid_q && (hold_dest_q == mem_dest)) begin
        hold_valid_d = 1'b0;
      end
    end else if (hold_valid_q) begin
      hold_valid_d = 1'b0;
      if (hold_dest_q != Zero) begin
        wr_en_d   = 1'b1;
        wr_addr_d = hold_dest_q;
        wr_data_d = hold_data_q;
      end
    end

    if (md_xfer) begin
      hold_valid_d = 1'b1;
      hold_dest_d  = md_dest;
      hold_data_d  = md_data;
    end

    if (hold_valid_q && hold_valid_d) begin
      wait_cnt_d = (wait_cnt_q == CntMax) ? CntMax : wait_cnt_q + CntW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_dest_q  <= '0;
      hold_data_q  <= '0;
      wait_cnt_q   <= '0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      hold_valid_q <= hold_valid_d;
      hold_dest_q  <= hold_dest_d;
      hold_data_q  <= hold_data_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign write_en      = wr_en_q;
  assign address_write = wr_addr_q;
  assign write_data    = wr_data_q;
  assign hold_pending  = hold_valid_q;
  assign hold_dest     = hold_dest_q;
  assign stall_req     = hold_valid_q && (wait_cnt_q == CntMax);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a write-port scoreboard.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic        mem_is_load;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_byte_off;
  logic [31:0] mem_rdata;
  logic        md_valid;
  logic [4:0]  md_dest;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  address_write;
  logic [31:0] write_data;
  logic        write_en;
  logic        hold_pending;
  logic [4:0]  hold_dest;
  logic        stall_req;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  passed = 0;

  writeback_stage dut (
    .clk           (clk),
    .reset         (reset),
    .mem_valid     (mem_valid),
    .mem_dest      (mem_dest),
    .mem_result    (mem_result),
    .mem_is_load   (mem_is_load),
    .mem_load_type (mem_load_type),
    .mem_byte_off  (mem_byte_off),
    .mem_rdata     (mem_rdata),
    .md_valid      (md_valid),
    .md_dest       (md_dest),
    .md_data       (md_data),
    .md_ready      (md_ready),
    .address_write (address_write),
    .write_data    (write_data),
    .write_en      (write_en),
    .hold_pending  (hold_pending),
    .hold_dest     (hold_dest),
    .stall_req     (stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Push the write expected at the very next edge.
  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare the write port against the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("wr_en", {31'b0, write_en}, 32'd1);
      chk("wr_addr", {27'b0, address_write}, {27'b0, e.addr});
      chk("wr_data", write_data, e.data);
    end else begin
      chk("wr_idle", {31'b0, write_en}, 32'd0);
    end
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] d, input logic [31:0] r);
    mem_valid   = v;
    mem_dest    = d;
    mem_result  = r;
    mem_is_load = 1'b0;
  endtask

  logic [2:0]  lt_tab  [7] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd3, 3'd4, 3'd0};
  logic [1:0]  off_tab [7] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
  logic [31:0] exp_tab [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F, 32'h0000_7F01,
                               32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};

  initial begin
    reset         = 1'b1;
    mem_valid     = 1'b1;
    mem_dest      = 5'd5;
    mem_result    = 32'h1234_5678;
    mem_is_load   = 1'b0;
    mem_load_type = 3'd0;
    mem_byte_off  = 2'd0;
    mem_rdata     = 32'h0;
    md_valid      = 1'b0;
    md_dest       = 5'd0;
    md_data       = 32'h0;

    // Reset held with a write offered: nothing commits.
    tick();
    tick();
    chk("rst_md_ready", {31'b0, md_ready}, 32'd1);
    chk("rst_stall", {31'b0, stall_req}, 32'd0);
    chk("rst_hold", {31'b0, hold_pending}, 32'd0);
    chk("rst_hold_dest", {27'b0, hold_dest}, 32'd0);
    chk("rst_addr", {27'b0, address_write}, 32'd0);
    chk("rst_data", write_data, 32'd0);

    // First ALU write after reset.
    reset = 1'b0;
    expect_wr(5'd5, 32'h1234_5678);
    tick();

    // Load extraction over rdata = 0x80FF_7F01.
    mem_is_load = 1'b1;
    mem_result  = 32'h5555_5555;
    mem_rdata   = 32'h80FF_7F01;
    for (int i = 0; i < 7; i++) begin
      mem_dest      = 5'(10 + i);
      mem_load_type = lt_tab[i];
      mem_byte_off  = off_tab[i];
      expect_wr(5'(10 + i), exp_tab[i]);
      tick();
    end

    // Destination $0 never writes.
    drive_alu(1'b1, 5'd0, 32'hDEAD_BEEF);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);

    // Mult/div accept then drain with the pipeline idle.
    chk("md_ready_idle", {31'b0, md_ready}, 32'd1);
    md_valid = 1'b1;
    md_dest  = 5'd9;
    md_data  = 32'hAAAA_0001;
    tick();
    md_valid = 1'b0;
    chk("md_ready_full", {31'b0, md_ready}, 32'd0);
    chk("hold_pending", {31'b0, hold_pending}, 32'd1);
    chk("hold_dest", {27'b0, hold_dest}, 32'd9);
    expect_wr(5'd9, 32'hAAAA_0001);
    tick();
    chk("md_ready_back", {31'b0, md_ready}, 32'd1);
    chk("hold_drained", {31'b0, hold_pending}, 32'd0);

    // Starvation: pipeline keeps winning until stall_req, then drops.
    md_valid = 1'b1;
    md_dest  = 5'd9;
    md_data  = 32'hBBBB_0002;
    drive_alu(1'b1, 5'd3, 32'h3333_0003);
    expect_wr(5'd3, 32'h3333_0003);
    tick();
    md_valid = 1'b0;
    chk("starve_st0", {31'b0, stall_req}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      expect_wr(5'd3, 32'h3333_0003);
      tick();
      chk("starve_st", {31'b0, stall_req}, (i == 4) ? 32'd1 : 32'd0);
    end
    expect_wr(5'd3, 32'h3333_0003);
    tick();
    chk("starve_hold", {31'b0, hold_pending}, 32'd1);
    chk("starve_sat", {31'b0, stall_req}, 32'd1);
    drive_alu(1'b0, 5'd0, 32'h0);
    expect_wr(5'd9, 32'hBBBB_0002);
    tick();
    chk("starve_clr", {31'b0, stall_req}, 32'd0);
    chk("starve_empty", {31'b0, hold_pending}, 32'd0);

    // Same-destination pipeline write drops the older held result.
    md_valid = 1'b1;
    md_dest  = 5'd7;
    md_data  = 32'h7777_0001;
    tick();
    md_valid = 1'b0;
    drive_alu(1'b1, 5'd7, 32'h7777_0002);
    expect_wr(5'd7, 32'h7777_0002);
    tick();
    chk("drop_hold", {31'b0, hold_pending}, 32'd0);
    drive_alu(1'b0, 5'd0, 32'h0);
    tick();

    // Held result to $0 is discarded silently.
    md_valid = 1'b1;
    md_dest  = 5'd0;
    md_data  = 32'h0BAD_0000;
    tick();
    md_valid = 1'b0;
    chk("zero_held", {31'b0, hold_pending}, 32'd1);
    tick();
    chk("zero_cleared", {31'b0, hold_pending}, 32'd0);

    // Reset mid-operation discards held entry and pending write.
    md_valid = 1'b1;
    md_dest  = 5'd12;
    md_data  = 32'hC0C0_C0C0;
    tick();
    md_valid = 1'b0;
    reset    = 1'b1;
    drive_alu(1'b1, 5'd4, 32'h4444_4444);
    tick();
    chk("mid_rst_hold", {31'b0, hold_pending}, 32'd0);
    chk("mid_rst_ready", {31'b0, md_ready}, 32'd1);
    reset = 1'b0;
    drive_alu(1'b0, 5'd0, 32'h0);
    tick();
    tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. It is the writer that drives the register file write port (address_write, write_data, write_en).
- Merges two result sources:
  - in-order MEM-stage results, including load-data alignment and extension;
  - asynchronous results from the multi-cycle mult/div unit, through a 1-entry holding buffer with a valid/ready handshake.
- Also exports the committed write for forwarding and hazard logic.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register address width
STARVE_LIMIT, 4, cycles a held mult/div result may wait before stall_req asserts

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
mem_valid  in  1  MEM stage has an instruction that writes a register
mem_dest  in  ADDR_W  destination register
mem_result  in  DATA_W  ALU/link result (non-load)
mem_is_load  in  1  select load path
mem_load_type  in  3  load_type_e (LW, LB, LBU, LH, LHU)
mem_byte_off  in  2  address[1:0] of the load
mem_rdata  in  DATA_W  raw word from data memory
md_valid  in  1  mult/div result offered
md_dest  in  ADDR_W  mult/div destination register
md_data  in  DATA_W  mult/div result
md_ready  out  1  holding buffer can accept (= !hold_valid)
address_write  out  ADDR_W  register file write address
write_data  out  DATA_W  register file write data
write_en  out  1  register file write enable
hold_pending  out  1  mult/div result waiting in buffer
hold_dest  out  ADDR_W  destination of held result (hazard check)
stall_req  out  1  request a pipeline bubble so held result drains

Behaviour:
- Reset values: write_en=0, address_write=0, write_data=0, hold_valid=0, hold_pending=0, hold_dest=0, wait counter=0, stall_req=0. Reset mid-operation discards any held result and the pending write.
- The write port outputs are registered.
- Latency: MEM inputs sampled at edge k produce outputs during cycle k..k+1. The register file commits at edge k+1.
- Load extraction is combinational, done before capture. Byte order is big-endian: byte_off 0 = bits[31:24].
  - LB/LBU: byte at byte_off, sign-extended / zero-extended.
  - LH/LHU: byte_off[1]=0 selects [31:16], 1 selects [15:0]. byte_off[0] is ignored (misalignment is trapped upstream).
  - LW and any unlisted encoding: raw word; byte_off is ignored.
- Mult/div handshake:
  - A transfer occurs on an edge where md_valid && md_ready. md_dest and md_data are then latched and hold_valid is set.
  - A source holding md_valid while md_ready=0 must keep its data stable.
- Arbitration per edge, in priority order:
  1. If mem_valid && mem_dest!=0: commit the pipeline write.
  2. Else if hold_valid && hold_dest!=0: commit the held write and clear hold_valid.
  3. Else: write_en=0.
- A held entry with hold_dest==0 is cleared with no write.
- Register $0 is never written: any write with dest 0 yields write_en=0.
- Ordering: the held result is older than any MEM-stage instruction. If the pipeline commits to dest == hold_dest while hold_valid, the held entry is dropped (hold_valid cleared, no write), because the younger write wins.
- A new md transfer cannot occur in the same edge as a drain, since md_ready is based on the current hold_valid. Minimum hold occupancy is 1 cycle.
- Starvation:
  - The wait counter increments each edge that hold_valid stays set. It saturates at STARVE_LIMIT and clears when hold_valid clears.
  - stall_req = hold_valid && counter==STARVE_LIMIT (combinational from registers).
  - If mem_valid still arrives while stall_req=1, the pipeline still wins priority.
- hold_pending = hold_valid. hold_dest is the registered held destination.

Decomposition:
- Shared package mips_pkg:
  - load_type_e with encodings LW=0, LB=1, LBU=2, LH=3, LHU=4;
  - DATA_W/ADDR_W defaults;
  - REG_ZERO constant.
- Sub-module load_align: combinational extractor with inputs load_type, byte_off, rdata and output aligned word. The rest (capture registers, hold buffer, arbiter, starvation counter) stays in writeback_stage.

Test Plan:
- Reset held 2 cycles with mem_valid=1 → write_en=0, md_ready=1, stall_req=0. Release: mem_valid=1, dest=5, result=0x1234_5678 → next cycle write_en=1, address_write=5, write_data=0x1234_5678.
- Loads with rdata=0x80FF_7F01:
  - LB off0 → 0xFFFF_FF80; LBU off0 → 0x0000_0080; LB off2 → 0x0000_007F;
  - LH off2 → 0x0000_7F01; LH off0 → 0xFFFF_80FF; LHU off1 → 0x0000_80FF.
- mem_valid=1, dest=0, result=0xDEAD_BEEF → write_en stays 0.
- md_valid with dest=9, data=0xAAAA_0001 while mem_valid idle → md_ready falls the next cycle; the write to 9 commits one cycle later; md_ready returns to 1.
- Held dest=9 while mem_valid continuous to dest=3 → stall_req asserts after 4 cycles. Drop mem_valid → dest 9 written, stall_req=0.
- Held dest=7, then mem_valid with dest=7 → only the pipeline value is written; hold_pending clears with no second write.
